// File: rtl/cdb_writeback_scheduler.sv
// Common-data-bus writeback scheduler: one small FIFO per functional unit and a
// round-robin arbiter that broadcasts at most one buffered result per cycle.
module cdb_writeback_scheduler #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2,
  parameter int UNITS = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         flush,
  input  logic [UNITS-1:0]             request,
  input  logic [UNITS*(WIDTH+1)-1:0]   result,
  input  logic [UNITS*(ROB+1)-1:0]     robEntry,
  output logic [UNITS-1:0]             available,
  output logic                         cdbValid,
  output logic [WIDTH:0]               cdbResult,
  output logic [ROB:0]                 cdbRob,
  output logic [$clog2(UNITS)-1:0]     cdbUnit
);

  localparam int UW = $clog2(UNITS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WIDTH:0] data;
    logic [ROB:0]   tag;
  } entry_t;

  entry_t          mem_q    [UNITS][DEPTH];
  entry_t          wr_entry [UNITS];
  logic [PW-1:0]   wr_ptr_q [UNITS];
  logic [PW-1:0]   wr_ptr_d [UNITS];
  logic [PW-1:0]   rd_ptr_q [UNITS];
  logic [PW-1:0]   rd_ptr_d [UNITS];
  logic [CW-1:0]   count_q  [UNITS];
  logic [CW-1:0]   count_d  [UNITS];
  logic [UW-1:0]   rr_q, rr_d;
  logic            valid_q, valid_d;
  entry_t          cdb_q, cdb_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [UNITS-1:0] push, pop;
  logic            grant_found;
  logic [UW-1:0]   grant;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int i = 0; i < UNITS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= UNITS) idx = idx - UNITS;
      if (!grant_found && count_q[idx] != '0) begin
        grant_found = 1'b1;
        grant       = UW'(idx);
      end
    end
  end

  // available uses the pre-edge count, so a full FIFO stays closed even while popped.
  always_comb begin
    for (int u = 0; u < UNITS; u++) begin
      available[u]     = (count_q[u] < CW'(DEPTH));
      push[u]          = request[u] & available[u] & ~flush;
      pop[u]           = grant_found & (grant == UW'(u)) & ~flush;
      wr_entry[u].data = result[u*(WIDTH+1) +: WIDTH+1];
      wr_entry[u].tag  = robEntry[u*(ROB+1) +: ROB+1];
    end
  end

  always_comb begin
    for (int u = 0; u < UNITS; u++) begin
      wr_ptr_d[u] = wr_ptr_q[u] + PW'(push[u]);
      rd_ptr_d[u] = rd_ptr_q[u] + PW'(pop[u]);
      count_d[u]  = count_q[u] + CW'(push[u]) - CW'(pop[u]);
      if (flush) begin
        wr_ptr_d[u] = '0;
        rd_ptr_d[u] = '0;
        count_d[u]  = '0;
      end
    end
    valid_d = grant_found & ~flush;
    cdb_d   = cdb_q;
    unit_d  = unit_q;
    rr_d    = rr_q;
    if (valid_d) begin
      cdb_d  = mem_q[grant][rd_ptr_q[grant]];
      unit_d = grant;
      rr_d   = (grant == UW'(UNITS - 1)) ? '0 : grant + UW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int u = 0; u < UNITS; u++) begin
        wr_ptr_q[u] <= '0;
        rd_ptr_q[u] <= '0;
        count_q[u]  <= '0;
      end
      rr_q    <= '0;
      valid_q <= 1'b0;
      cdb_q   <= '0;
      unit_q  <= '0;
    end else begin
      for (int u = 0; u < UNITS; u++) begin
        wr_ptr_q[u] <= wr_ptr_d[u];
        rd_ptr_q[u] <= rd_ptr_d[u];
        count_q[u]  <= count_d[u];
      end
      rr_q    <= rr_d;
      valid_q <= valid_d;
      cdb_q   <= cdb_d;
      unit_q  <= unit_d;
    end
  end

  // NOTE: FIFO storage has no reset; the counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int u = 0; u < UNITS; u++) begin
      if (push[u]) mem_q[u][wr_ptr_q[u]] <= wr_entry[u];
    end
  end

  assign cdbValid  = valid_q;
  assign cdbResult = cdb_q.data;
  assign cdbRob    = cdb_q.tag;
  assign cdbUnit   = unit_q;

endmodule

// File: tb/tb_cdb_writeback_scheduler.sv
// Directed self-checking bench for cdb_writeback_scheduler with hand-derived expectations.
module tb_cdb_writeback_scheduler;

  localparam int WIDTH = 31;
  localparam int ROB   = 2;
  localparam int UNITS = 4;
  localparam int DEPTH = 2;

  logic                       clk = 1'b0;
  logic                       clear = 1'b0;
  logic                       flush = 1'b0;
  logic [UNITS-1:0]           request = '0;
  logic [UNITS*(WIDTH+1)-1:0] result = '0;
  logic [UNITS*(ROB+1)-1:0]   robEntry = '0;
  logic [UNITS-1:0]           available;
  logic                       cdbValid;
  logic [WIDTH:0]             cdbResult;
  logic [ROB:0]               cdbRob;
  logic [1:0]                 cdbUnit;
  logic [37:0]                cdb_obs;

  int checks = 0;
  int failures = 0;

  cdb_writeback_scheduler #(.WIDTH(WIDTH), .ROB(ROB), .UNITS(UNITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .clear(clear), .flush(flush), .request(request), .result(result),
    .robEntry(robEntry), .available(available), .cdbValid(cdbValid),
    .cdbResult(cdbResult), .cdbRob(cdbRob), .cdbUnit(cdbUnit)
  );

  always #5 clk = ~clk;

  // {valid, unit, tag, result}
  assign cdb_obs = {cdbValid, cdbUnit, cdbRob, cdbResult};

  // A request into a closed FIFO would be silently dropped by the design.
  always @(posedge clk) begin
    if (!clear && (request & ~available) != '0) begin
      checks++;
      failures++;
      $display("FAIL protocol request=%b available=%b", request, available);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic [31:0] d, input logic [2:0] t);
    request[u]              = 1'b1;
    result[u*32 +: 32]      = d;
    robEntry[u*3 +: 3]      = t;
  endtask

  task automatic reset_dut();
    request = '0;
    flush   = 1'b0;
    clear   = 1'b1;
    @(posedge clk);
    #2;
    clear = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [37:0] exp;
    #1 clear = 1'b1;
    #2;
    exp = '0;
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL reset_cdb got=%h exp=%h", cdb_obs, exp);
    end
    checks++;
    if (available !== 4'hF) begin
      failures++;
      $display("FAIL reset_available got=%b exp=%b", available, 4'hF);
    end
    #20;
    clear = 1'b0;
    #1;
  endtask

  task automatic test_single_alu();
    logic [37:0] exp;
    reset_dut();
    drive(0, 32'd60, 3'd1);
    tick();
    request = '0;
    checks++;
    if (cdbValid !== 1'b0) begin
      failures++;
      $display("FAIL single_no_bypass got=%b exp=0", cdbValid);
    end
    tick();
    exp = {1'b1, 2'd0, 3'd1, 32'd60};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL single_bcast got=%h exp=%h", cdb_obs, exp);
    end
    tick();
    exp = {1'b0, 2'd0, 3'd1, 32'd60};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL single_idle_hold got=%h exp=%h", cdb_obs, exp);
    end
  endtask

  task automatic test_simultaneous();
    logic [37:0] exp;
    reset_dut();
    drive(0, 32'd10, 3'd2);
    drive(1, 32'd20, 3'd3);
    tick();
    request = '0;
    tick();
    exp = {1'b1, 2'd0, 3'd2, 32'd10};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL simul_alu got=%h exp=%h", cdb_obs, exp);
    end
    tick();
    exp = {1'b1, 2'd1, 3'd3, 32'd20};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL simul_branch got=%h exp=%h", cdb_obs, exp);
    end
    // Pointer should now be 2: unit 2 beats unit 1.
    drive(1, 32'd111, 3'd4);
    drive(2, 32'd222, 3'd5);
    tick();
    request = '0;
    tick();
    exp = {1'b1, 2'd2, 3'd5, 32'd222};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL simul_ptr2_first got=%h exp=%h", cdb_obs, exp);
    end
    tick();
    exp = {1'b1, 2'd1, 3'd4, 32'd111};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL simul_ptr2_second got=%h exp=%h", cdb_obs, exp);
    end
  endtask

  task automatic test_rr_wrap();
    logic [37:0] exp;
    reset_dut();
    drive(2, 32'd5, 3'd0);
    tick();
    request = '0;
    tick();
    checks++;
    if (cdbUnit !== 2'd2 || cdbValid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_setup got=%b/%0d exp=1/2", cdbValid, cdbUnit);
    end
    drive(0, 32'd30, 3'd6);
    drive(3, 32'd33, 3'd7);
    tick();
    request = '0;
    tick();
    exp = {1'b1, 2'd3, 3'd7, 32'd33};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL wrap_unit3 got=%h exp=%h", cdb_obs, exp);
    end
    tick();
    exp = {1'b1, 2'd0, 3'd6, 32'd30};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL wrap_unit0 got=%h exp=%h", cdb_obs, exp);
    end
    // Pointer should now be 1: unit 1 beats unit 0.
    drive(0, 32'd40, 3'd0);
    drive(1, 32'd41, 3'd1);
    tick();
    request = '0;
    tick();
    exp = {1'b1, 2'd1, 3'd1, 32'd41};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL wrap_ptr1 got=%h exp=%h", cdb_obs, exp);
    end
    tick();
    exp = {1'b1, 2'd0, 3'd0, 32'd40};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL wrap_ptr1_next got=%h exp=%h", cdb_obs, exp);
    end
  endtask

  task automatic test_backpressure();
    int          seq [UNITS];
    logic [31:0] q1_data [$];
    logic [2:0]  q1_tag [$];
    logic [1:0]  exp_unit;
    logic [31:0] ed;
    logic [2:0]  et;
    reset_dut();
    for (int u = 0; u < UNITS; u++) seq[u] = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      request = '0;
      for (int u = 0; u < UNITS; u++) begin
        if (available[u]) begin
          drive(u, 32'(u * 1000 + seq[u]), 3'(seq[u]));
          if (u == 1) begin
            q1_data.push_back(32'(1000 + seq[u]));
            q1_tag.push_back(3'(seq[u]));
          end
          seq[u]++;
        end
      end
      tick();
      if (cyc == 0) begin
        checks++;
        if (cdbValid !== 1'b0 || available !== 4'hF) begin
          failures++;
          $display("FAIL bp_first got=%b/%b exp=0/1111", cdbValid, available);
        end
      end else begin
        exp_unit = 2'((cyc - 1) % 4);
        checks++;
        if (cdbValid !== 1'b1 || cdbUnit !== exp_unit) begin
          failures++;
          $display("FAIL bp_grant cyc=%0d got=%b/%0d exp=1/%0d", cyc, cdbValid, cdbUnit, exp_unit);
        end
        checks++;
        if (available !== (4'b0001 << exp_unit)) begin
          failures++;
          $display("FAIL bp_available cyc=%0d got=%b exp=%b", cyc, available, 4'b0001 << exp_unit);
        end
      end
      if (cdbValid === 1'b1 && cdbUnit === 2'd1) begin
        checks++;
        if (q1_data.size() == 0) begin
          failures++;
          $display("FAIL bp_unit1_extra got=%0d exp=none", cdbResult);
        end else begin
          ed = q1_data.pop_front();
          et = q1_tag.pop_front();
          if (cdbResult !== ed || cdbRob !== et) begin
            failures++;
            $display("FAIL bp_unit1_order got=%0d/%0d exp=%0d/%0d", cdbResult, cdbRob, ed, et);
          end
        end
      end
    end
    request = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (cdbValid === 1'b1 && cdbUnit === 2'd1) begin
        checks++;
        if (q1_data.size() == 0) begin
          failures++;
          $display("FAIL bp_drain_extra got=%0d exp=none", cdbResult);
        end else begin
          ed = q1_data.pop_front();
          et = q1_tag.pop_front();
          if (cdbResult !== ed || cdbRob !== et) begin
            failures++;
            $display("FAIL bp_drain_order got=%0d/%0d exp=%0d/%0d", cdbResult, cdbRob, ed, et);
          end
        end
      end
    end
    checks++;
    if (q1_data.size() != 0) begin
      failures++;
      $display("FAIL bp_lost got=%0d exp=0", q1_data.size());
    end
  endtask

  task automatic test_flush();
    logic [37:0] exp;
    reset_dut();
    drive(0, 32'd1, 3'd1);
    drive(2, 32'd2, 3'd2);
    tick();
    request = '0;
    drive(0, 32'd3, 3'd3);
    drive(2, 32'd4, 3'd4);
    tick();
    request = '0;
    flush   = 1'b1;
    drive(1, 32'd555, 3'd5);
    tick();
    flush   = 1'b0;
    request = '0;
    checks++;
    if (cdbValid !== 1'b0 || available !== 4'hF) begin
      failures++;
      $display("FAIL flush_state got=%b/%b exp=0/1111", cdbValid, available);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      checks++;
      if (cdbValid !== 1'b0) begin
        failures++;
        $display("FAIL flush_leak cyc=%0d got=%0d/%0d exp=idle", cyc, cdbUnit, cdbResult);
      end
    end
    // Pointer was 1 before the flush and must still be 1.
    drive(0, 32'd70, 3'd0);
    drive(1, 32'd71, 3'd1);
    tick();
    request = '0;
    tick();
    exp = {1'b1, 2'd1, 3'd1, 32'd71};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL flush_ptr got=%h exp=%h", cdb_obs, exp);
    end
  endtask

  task automatic test_async_clear();
    logic [37:0] exp;
    reset_dut();
    drive(0, 32'd77, 3'd5);
    drive(3, 32'd88, 3'd6);
    tick();
    request = '0;
    tick();
    exp = {1'b1, 2'd0, 3'd5, 32'd77};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL aclr_before got=%h exp=%h", cdb_obs, exp);
    end
    #2 clear = 1'b1;
    #1;
    exp = '0;
    checks++;
    if (cdb_obs !== exp || available !== 4'hF) begin
      failures++;
      $display("FAIL aclr_immediate got=%h/%b exp=%h/1111", cdb_obs, available, exp);
    end
    @(posedge clk);
    #2 clear = 1'b0;
    tick();
    checks++;
    if (cdbValid !== 1'b0) begin
      failures++;
      $display("FAIL aclr_stale got=%0d/%0d exp=idle", cdbUnit, cdbResult);
    end
    drive(2, 32'd99, 3'd1);
    tick();
    request = '0;
    tick();
    exp = {1'b1, 2'd2, 3'd1, 32'd99};
    checks++;
    if (cdb_obs !== exp) begin
      failures++;
      $display("FAIL aclr_fresh got=%h exp=%h", cdb_obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_rr_wrap();
    test_backpressure();
    test_flush();
    test_async_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
